dmem_responder: RTL and testbench

Single-port data-memory target that answers the core's MEM-stage load/store requests over a valid/ready request and response handshake. It is the responder for the memory interface the pipeline drives from `ex_mem_t` (`is_mem_read`, `is_mem_write`, byte strobes derived from `is_memsize_*`). It holds word-organised storage with byte-lane write enables, inserts a configurable number of wait states, and has one request outstanding at a time.

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Single-port data-memory target for the core's MEM-stage load/store traffic.
// It accepts one request at a time over a valid/ready handshake. After
// WAIT_CYCLES extra cycles it returns the result on a second valid/ready
// handshake.
//
// Storage is word-organised and has per-byte write strobes. A store commits
// on its accept edge, so a load issued right after it sees the new data.
//
// Optional feature, selected by the DMEM_ERR_EN macro:
//   defined   : an out-of-range access returns rsp_err_o = 1 and
//               rsp_rdata_o = 0, and it writes nothing to memory.
//   undefined : the word index wraps modulo DEPTH_WORDS, so addresses alias,
//               and rsp_err_o is tied to 0.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//   WAIT_CYCLES  extra cycles between accept and response (0..15)
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   req_valid_i  request present
//   req_ready_o  responder can accept (IDLE only)
//   req_we_i     1 = store, 0 = load
//   req_addr_i   byte address; bits [1:0] are ignored
//   req_wmask_i  byte-lane write strobes; ignored for loads
//   req_wdata_i  lane-aligned store data
//   rsp_valid_o  response present (RESP only)
//   rsp_ready_i  requester takes the response
//   rsp_rdata_o  loaded word; 0 for stores and errors
//   rsp_err_o    access fault; meaningful while rsp_valid_o = 1
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [3:0]  req_wmask_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // The counter runs from WAIT_CYCLES-1 down to 0, which gives exactly
    // WAIT_CYCLES cycles in WAIT.
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]  r_state;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0]      w_offset;
    logic [IDX_W-1:0] w_idx;
    logic             w_in_range;
    logic             w_accept;
    logic             w_write;

    // The subtraction wraps modulo 2^32, so addresses below BASE_ADDR become
    // large offsets and fall out of range.
    assign w_offset = req_addr_i - BASE_ADDR;

    // Taking only the low index bits is what makes addresses alias when the
    // range check is disabled.
    assign w_idx = w_offset[IDX_W+1:2];

`ifdef DMEM_ERR_EN
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
    assign w_in_range = ({1'b0, w_offset} < SPAN_BYTES);
`else
    assign w_in_range = 1'b1;
`endif

    // Ready and valid are plain decodes of the state register, so neither
    // has a combinational path from any input.
    assign req_ready_o = (r_state == ST_IDLE);
    assign rsp_valid_o = (r_state == ST_RESP);
    assign rsp_rdata_o = r_rdata;

    assign w_accept = req_valid_i & req_ready_o;
    assign w_write  = w_accept & req_we_i & w_in_range;

    // NOTE: the memory array has no reset branch. Its contents are undefined
    // until written, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk_i) begin
        if (w_write) begin
            for (int n = 0; n < 4; n++) begin
                if (req_wmask_i[n]) begin
                    r_mem[w_idx][8*n +: 8] <= req_wdata_i[8*n +: 8];
                end
            end
        end
    end

`ifdef DMEM_ERR_EN
    logic r_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= ~w_in_range;
        end
    end

    assign rsp_err_o = r_err;
`else
    assign rsp_err_o = 1'b0;
`endif

    // NOTE: every state register uses non-blocking assignments. All of them
    // then update together on the edge, whatever order they are read in.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
            r_rdata    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Stores and faulting accesses return a zero word.
                        r_rdata <= (!req_we_i && w_in_range) ? r_mem[w_idx] : 32'd0;
                        if (WAIT_CYCLES > 0) begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= WAIT_INIT;
                        end else begin
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. It uses three instances:
//   d=0 : WAIT_CYCLES=0, BASE_ADDR=0
//   d=1 : WAIT_CYCLES=3, BASE_ADDR=0
//   d=2 : WAIT_CYCLES=5, BASE_ADDR=32'h8000_0000
// Every instance has DEPTH_WORDS = 1024.
//
// Expected values for out-of-range accesses depend on whether the
// DMEM_ERR_EN macro is defined.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int N = 3;

`ifdef DMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        req_valid [N];
    logic        req_ready [N];
    logic        req_we    [N];
    logic [31:0] req_addr  [N];
    logic [3:0]  req_wmask [N];
    logic [31:0] req_wdata [N];
    logic        rsp_valid [N];
    logic        rsp_ready [N];
    logic [31:0] rsp_rdata [N];
    logic        rsp_err   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned WC = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
        localparam logic [31:0] BA = (g == 2) ? 32'h8000_0000 : 32'h0000_0000;

        dmem_responder #(
            .DEPTH_WORDS(1024),
            .BASE_ADDR  (BA),
            .WAIT_CYCLES(WC)
        ) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .req_valid_i(req_valid[g]),
            .req_ready_o(req_ready[g]),
            .req_we_i   (req_we[g]),
            .req_addr_i (req_addr[g]),
            .req_wmask_i(req_wmask[g]),
            .req_wdata_i(req_wdata[g]),
            .rsp_valid_o(rsp_valid[g]),
            .rsp_ready_i(rsp_ready[g]),
            .rsp_rdata_o(rsp_rdata[g]),
            .rsp_err_o  (rsp_err[g])
        );
    end

    // Present a request and hold it until it is accepted; return just after
    // the accept edge. The wait for ready is bounded.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] wdata);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 64) begin
            @(negedge clk);
            n++;
        end
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wmask[d] = mask;
        req_wdata[d] = wdata;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
    endtask

    // lat is the number of edges from accept until valid is seen before an
    // edge. It is -1 on timeout.
    task automatic wait_rsp(input int d, output int lat);
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (rsp_valid[d] === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic release_rsp(input int d);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[d] = 1'b0;
    endtask

    task automatic xact(input int d, input logic we, input logic [31:0] addr,
                        input logic [3:0] mask, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
        issue(d, we, addr, mask, wdata);
        wait_rsp(d, lat);
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        if (lat > 0) release_rsp(d);
    endtask

    task automatic test_reset();
        for (int d = 0; d < N; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'h0;
            req_wmask[d] = 4'h0;
            req_wdata[d] = 32'h0;
            rsp_ready[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            total++;
            if (req_ready[d] !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready d=%0d: got %b want 1", d, req_ready[d]);
            end
            total++;
            if (rsp_valid[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_valid d=%0d: got %b want 0", d, rsp_valid[d]);
            end
            total++;
            if (rsp_rdata[d] !== 32'h0) begin
                bad++;
                $display("FAIL reset_rdata d=%0d: got %h want 0", d, rsp_rdata[d]);
            end
            total++;
            if (rsp_err[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_err d=%0d: got %b want 0", d, rsp_err[d]);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] rd;
        logic er;
        xact(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, lat, rd, er);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL basic_st_lat: got %0d want 1", lat);
        end
        total++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            bad++;
            $display("FAIL basic_st_rsp: got rdata=%h err=%b want 0/0", rd, er);
        end
        xact(0, 1'b0, 32'h10, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL basic_ld_lat: got %0d want 1", lat);
        end
        total++;
        if (rd !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL basic_ld_data: got %h want deadbeef", rd);
        end
        total++;
        if (er !== 1'b0) begin
            bad++;
            $display("FAIL basic_ld_err: got %b want 0", er);
        end
    endtask

    task automatic test_byte_lanes();
        int lat;
        logic [31:0] rd;
        logic er;
        xact(0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, lat, rd, er);
        xact(0, 1'b1, 32'h20, 4'b1000, 32'hAA00_0000, lat, rd, er);
        xact(0, 1'b0, 32'h20, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hAA22_3344) begin
            bad++;
            $display("FAIL lanes_msb: got %h want aa223344", rd);
        end
        xact(0, 1'b1, 32'h20, 4'b0000, 32'h5555_5555, lat, rd, er);
        total++;
        if (er !== 1'b0) begin
            bad++;
            $display("FAIL lanes_zero_mask_err: got %b want 0", er);
        end
        xact(0, 1'b0, 32'h22, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'hAA22_3344) begin
            bad++;
            $display("FAIL lanes_zero_mask: got %h want aa223344", rd);
        end
    endtask

    task automatic test_back_to_back();
        int acc;
        int lat;
        logic [31:0] rd;
        logic er;
        acc = 0;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h30;
        req_wmask[0] = 4'hF;
        req_wdata[0] = 32'h0F0E_0D0C;
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (req_ready[0] === 1'b1 && req_valid[0] === 1'b1) acc++;
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b0;
        total++;
        if (acc !== 4) begin
            bad++;
            $display("FAIL b2b_accepts: got %0d in 8 cycles want 4", acc);
        end
        total++;
        if (req_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle: got ready=%b want 1", req_ready[0]);
        end
        xact(0, 1'b0, 32'h30, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (rd !== 32'h0F0E_0D0C) begin
            bad++;
            $display("FAIL b2b_data: got %h want 0f0e0d0c", rd);
        end
    endtask

    task automatic test_wait3();
        int lat;
        int hold_bad;
        logic [31:0] rd;
        logic er;
        xact(1, 1'b1, 32'h40, 4'hF, 32'h1234_5678, lat, rd, er);
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL w3_st_lat: got %0d want 4", lat);
        end
        issue(1, 1'b0, 32'h40, 4'h0, 32'h0);
        wait_rsp(1, lat);
        total++;
        if (lat !== 4) begin
            bad++;
            $display("FAIL w3_ld_lat: got %0d want 4", lat);
        end
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'h1234_5678 ||
                rsp_err[1] !== 1'b0 || req_ready[1] !== 1'b0) hold_bad++;
        end
        total++;
        if (hold_bad !== 0) begin
            bad++;
            $display("FAIL w3_hold: got %0d unstable cycles want 0", hold_bad);
        end
        release_rsp(1);
        @(negedge clk);
        total++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin
            bad++;
            $display("FAIL w3_release: got ready=%b valid=%b want 1/0",
                     req_ready[1], rsp_valid[1]);
        end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [31:0] rd;
        logic er;
        xact(0, 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, lat, rd, er);
        xact(0, 1'b0, 32'h1000, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL oor_ld_lat: got %0d want 1", lat);
        end
        total++;
        if (er !== ERR_EN) begin
            bad++;
            $display("FAIL oor_ld_err: got %b want %b", er, ERR_EN);
        end
        total++;
        if (rd !== (ERR_EN ? 32'h0 : 32'hCAFE_F00D)) begin
            bad++;
            $display("FAIL oor_ld_data: got %h want %h", rd,
                     (ERR_EN ? 32'h0 : 32'hCAFE_F00D));
        end
        xact(0, 1'b1, 32'h1000, 4'hF, 32'h0BAD_BEEF, lat, rd, er);
        total++;
        if (er !== ERR_EN) begin
            bad++;
            $display("FAIL oor_st_err: got %b want %b", er, ERR_EN);
        end
        xact(0, 1'b0, 32'h0, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (rd !== (ERR_EN ? 32'hCAFE_F00D : 32'h0BAD_BEEF)) begin
            bad++;
            $display("FAIL oor_word0: got %h want %h", rd,
                     (ERR_EN ? 32'hCAFE_F00D : 32'h0BAD_BEEF));
        end
    endtask

    task automatic test_reset_mid_wait();
        int lat;
        int seen;
        logic [31:0] rd;
        logic er;
        issue(2, 1'b1, 32'h8000_0100, 4'hF, 32'h5A5A_A5A5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
            bad++;
            $display("FAIL rmw_async: got ready=%b valid=%b want 1/0",
                     req_ready[2], rsp_valid[2]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid[2] !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL rmw_no_rsp: got valid in %0d cycles want 0", seen);
        end
        xact(2, 1'b0, 32'h8000_0100, 4'h0, 32'h0, lat, rd, er);
        total++;
        if (lat !== 6) begin
            bad++;
            $display("FAIL rmw_ld_lat: got %0d want 6", lat);
        end
        total++;
        if (rd !== 32'h5A5A_A5A5) begin
            bad++;
            $display("FAIL rmw_ld_data: got %h want 5a5aa5a5", rd);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_back_to_back();
        test_wait3();
        test_out_of_range();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
